truth_table_sweeper: RTL

Clocked, parametrised truth-table checker for the lab's combinational gate-level/operator blocks. Drives an N_IN-bit input vector into up to N_CH DUT channels in parallel, sweeps all 2^N_IN combinations in ascending order, and compares each channel's output against a golden table. Records per-channel pass/fail, a saturating mismatch count and the first failing vector. Replaces hand-written per-vector stimulus, and can run on the board with the DUT outputs wired back in.

---
 rtl/truth_table_sweeper.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps every N_IN-bit input vector in ascending order
// into N_CH DUT channels and checks each channel's output bit against a
// golden table.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      begin a sweep (only from IDLE) / stop an active sweep
//   ch_enable[N_CH]   per-channel compare enable, latched on accepted start
//   dut_y[N_CH]       DUT outputs, one bit per channel
//   vec_out[N_IN]     stimulus vector driven to every DUT (MSB = input A)
//   busy, done        sweep in progress / one-cycle completion pulse
//   pass              no enabled channel failed (valid from done to next start)
//   fail_mask[N_CH]   sticky per-channel mismatch flags
//   err_count[CNT_W]  saturating total mismatch count
//   first_fail_vec    vector of the first mismatch, qualified by first_fail_valid

// Per-channel compare: a mismatch is an enabled channel whose output
// disagrees with its golden bit for the current vector.
module tts_lane #(
  parameter int N_IN = 3
) (
  input  logic [(1<<N_IN)-1:0] exp_row,
  input  logic [N_IN-1:0]      vec,
  input  logic                 y,
  input  logic                 en,
  output logic                 mism
);
  assign mism = en & (y ^ exp_row[vec]);
endmodule

module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int N_CH   = 8,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16,
  parameter logic [N_CH*(1<<N_IN)-1:0] EXPECTED = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_CH-1:0]  ch_enable,
  input  logic [N_CH-1:0]  dut_y,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_CH-1:0]  fail_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);
  localparam int NV    = 1 << N_IN;
  localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW    = $clog2(N_CH + 1);
  localparam int SUM_W = CNT_W + PW;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     settle_cnt;
  logic [N_CH-1:0]   en_q;
  logic [N_CH-1:0]   mism;
  logic [PW-1:0]     pop;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  err_sat;
  logic [N_CH-1:0]   fail_nx;
  logic              accept, smp, last_vec;

  // Abort has priority over start in IDLE and over the sample in SAMPLE:
  // an aborted sample cycle leaves the partial results untouched.
  assign accept   = (state == IDLE) && start && !abort;
  assign smp      = (state == SAMPLE) && !abort;
  assign last_vec = (vec_out == N_IN'(NV - 1));

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    tts_lane #(.N_IN(N_IN)) u_lane (
      .exp_row (EXPECTED[c*NV +: NV]),
      .vec     (vec_out),
      .y       (dut_y[c]),
      .en      (en_q[c]),
      .mism    (mism[c])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + PW'(mism[i]);
  end

  // Widened add so the clamp sees the true sum before truncation.
  assign sum     = SUM_W'(err_count) + SUM_W'(pop);
  assign err_sat = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  assign fail_nx = fail_mask | mism;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept) state_nx = APPLY;
      APPLY:  if (abort) state_nx = IDLE;
              else if (settle_cnt == SW'(SETTLE - 1)) state_nx = SAMPLE;
      SAMPLE: if (abort) state_nx = IDLE;
              else if (last_vec) state_nx = DONE;
              else state_nx = APPLY;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt       <= '0;
      en_q             <= '0;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_mask        <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      // busy/done are registered copies of the next state so they line up
      // exactly with the state they describe.
      busy <= (state_nx == APPLY) || (state_nx == SAMPLE);
      done <= (state_nx == DONE);
      if (accept) begin
        vec_out          <= '0;
        settle_cnt       <= '0;
        en_q             <= ch_enable;
        pass             <= 1'b0;
        fail_mask        <= '0;
        err_count        <= '0;
        first_fail_vec   <= '0;
        first_fail_valid <= 1'b0;
      end
      if (state == APPLY) settle_cnt <= settle_cnt + SW'(1);
      if (state == SAMPLE) settle_cnt <= '0;
      if (smp) begin
        fail_mask <= fail_nx;
        err_count <= err_sat;
        if ((mism != '0) && !first_fail_valid) begin
          first_fail_vec   <= vec_out;
          first_fail_valid <= 1'b1;
        end
        if (last_vec) pass <= (fail_nx == '0);
        else          vec_out <= vec_out + N_IN'(1);
      end
    end
  end
endmodule
